// File: rtl/add_sub_sched.sv
// Round-robin scheduler that shares one two-phase add/sub accumulator datapath
// between NREQ requesters. A per-phase watchdog aborts a stalled datapath.
module add_sub_sched #(
  parameter int unsigned BITS    = 32,
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ-1:0]      req_nadd_sub,
  input  logic [NREQ-1:0]      req_use_prev,
  input  logic [NREQ*BITS-1:0] req_data,
  output logic                 resp_valid,
  output logic [2:0]           resp_id,
  output logic [BITS-1:0]      resp_data,
  output logic                 resp_err,
  output logic                 busy,
  output logic                 dp_valid,
  output logic                 dp_we,
  output logic                 dp_nadd_sub,
  output logic                 dp_use_prev,
  output logic [BITS-1:0]      dp_wdata,
  input  logic                 dp_ready,
  input  logic [BITS-1:0]      dp_rdata
);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]      state;
  logic [PW-1:0]   ptr;
  logic [WW-1:0]   wd;
  logic [BITS-1:0] op_data;
  logic            op_nas;
  logic            op_up;
  logic [PW-1:0]   op_id;

  logic            grant_found;
  logic [PW-1:0]   grant_id;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] grant_vec;
  logic [BITS-1:0] grant_data;
  logic            grant_nas;
  logic            grant_up;
  int unsigned     ptr_u;

  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_vec   = '0;
    grant_data  = '0;
    grant_nas   = 1'b0;
    grant_up    = 1'b0;
    ptr_u       = 32'(ptr);
    // Pass 0 scans requesters at or above the pointer, pass 1 the wrapped ones.
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!grant_found && req_valid[i] && ((pass == 0) == (i >= ptr_u))) begin
          grant_found  = 1'b1;
          grant_id     = PW'(i);
          grant_vec[i] = 1'b1;
          grant_data   = req_data[i*BITS +: BITS];
          grant_nas    = req_nadd_sub[i];
          grant_up     = req_use_prev[i];
        end
      end
    end
    ptr_next = (32'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      wd        <= '0;
      op_data   <= '0;
      op_nas    <= 1'b0;
      op_up     <= 1'b0;
      op_id     <= '0;
      resp_data <= '0;
      resp_id   <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            op_data <= grant_data;
            op_nas  <= grant_nas;
            op_up   <= grant_up;
            op_id   <= grant_id;
            ptr     <= ptr_next;
            wd      <= '0;
            state   <= S_WR;
          end
        end
        S_WR: begin
          if (dp_ready) begin
            state <= S_GAP;
          end else if (wd == WD_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            resp_id   <= 3'(op_id);
            state     <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_GAP: begin
          wd    <= '0;
          state <= S_RD;
        end
        S_RD: begin
          // Ready in the expiry cycle takes precedence over the abort.
          if (dp_ready) begin
            resp_data <= dp_rdata;
            resp_err  <= 1'b0;
            resp_id   <= 3'(op_id);
            state     <= S_RESP;
          end else if (wd == WD_LAST) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
            resp_id   <= 3'(op_id);
            state     <= S_RESP;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = (state == S_IDLE && !reset) ? grant_vec : '0;
  assign busy        = (state != S_IDLE);
  assign dp_valid    = (state == S_WR) || (state == S_RD);
  assign dp_we       = (state == S_WR);
  assign dp_nadd_sub = op_nas;
  assign dp_use_prev = op_up;
  assign dp_wdata    = op_data;
  assign resp_valid  = (state == S_RESP);

endmodule

// File: tb/tb_add_sub_sched.sv
// Bench for add_sub_sched: accumulator-style datapath stand-in plus a
// plain-arithmetic reference of the accumulated result.
module tb_add_sub_sched;
  localparam int unsigned BITS    = 32;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned TIMEOUT = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid, req_ready, req_nadd_sub, req_use_prev;
  logic [NREQ*BITS-1:0] req_data;
  logic                 resp_valid, resp_err, busy;
  logic [2:0]           resp_id;
  logic [BITS-1:0]      resp_data;
  logic                 dp_valid, dp_we, dp_nadd_sub, dp_use_prev;
  logic [BITS-1:0]      dp_wdata;
  logic                 dp_ready;
  logic [BITS-1:0]      dp_rdata = '0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int wr_dly = 0;
  int rd_dly = 0;
  logic [BITS-1:0] ref_prev = '0;

  add_sub_sched #(.BITS(BITS), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_nadd_sub(req_nadd_sub),
    .req_use_prev(req_use_prev), .req_data(req_data),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy), .dp_valid(dp_valid), .dp_we(dp_we), .dp_nadd_sub(dp_nadd_sub),
    .dp_use_prev(dp_use_prev), .dp_wdata(dp_wdata), .dp_ready(dp_ready), .dp_rdata(dp_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result of one accumulator operation: prev +/- operand, or hi +/- lo halves.
  function automatic logic [BITS-1:0] ref_acc(input logic [BITS-1:0] prev, input logic [BITS-1:0] d,
                                               input logic nas, input logic up);
    logic [BITS-1:0] a, b;
    if (up) begin a = prev; b = d; end
    else begin a = BITS'(d[BITS-1:BITS/2]); b = BITS'(d[BITS/2-1:0]); end
    return nas ? a - b : a + b;
  endfunction

  // Datapath stand-in: ready pulses after a programmable number of valid cycles.
  logic [BITS-1:0] m_w = '0, m_prev = '0;
  logic            m_nas = 1'b0, m_up = 1'b0;
  int              m_cnt = 0;
  always @(posedge clk) begin
    if (reset) begin
      dp_ready <= 1'b0;
      m_cnt    <= 0;
    end else if (dp_valid && !dp_ready) begin
      if (m_cnt >= (dp_we ? wr_dly : rd_dly)) begin
        dp_ready <= 1'b1;
        m_cnt    <= 0;
        if (dp_we) begin
          m_w <= dp_wdata; m_nas <= dp_nadd_sub; m_up <= dp_use_prev;
        end else begin
          dp_rdata <= ref_acc(m_prev, m_w, m_nas, m_up);
          m_prev   <= ref_acc(m_prev, m_w, m_nas, m_up);
        end
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else begin
      dp_ready <= 1'b0;
      if (!dp_valid) m_cnt <= 0;
    end
  end

  task automatic drive_req(input int i, input logic [BITS-1:0] d, input logic nas, input logic up);
    req_valid[i] = 1'b1;
    req_data[i*BITS +: BITS] = d;
    req_nadd_sub[i] = nas;
    req_use_prev[i] = up;
  endtask

  task automatic wait_accept(input int i, output int acc, output bit ok);
    ok = 1'b0; acc = 0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      if (req_ready[i]) begin ok = 1'b1; acc = cyc; end
    end
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(output int rc, output bit ok, output logic [2:0] id,
                           output logic [BITS-1:0] d, output logic e, output int nwr, output int nrd);
    ok = 1'b0; rc = 0; id = '0; d = '0; e = 1'b0; nwr = 0; nrd = 0;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (dp_valid && dp_we) nwr++;
      if (dp_valid && !dp_we) nrd++;
      if (resp_valid) begin ok = 1'b1; rc = cyc; id = resp_id; d = resp_data; e = resp_err; end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '1; req_data = '1; req_nadd_sub = '1; req_use_prev = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_data, resp_err, busy, dp_valid, dp_we,
         dp_nadd_sub, dp_use_prev, dp_wdata} !== '0)
      begin errors++; $display("FAIL reset_outputs: got busy=%b dp_valid=%b req_ready=%b wdata=%h expected all 0",
                               busy, dp_valid, req_ready, dp_wdata); end
    @(posedge clk); #1;
    req_valid = '0; req_data = '0; req_nadd_sub = '0; req_use_prev = '0; reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_id, resp_data, resp_err, busy, dp_valid} !== '0)
      begin errors++; $display("FAIL post_reset_idle: got busy=%b resp_valid=%b expected 0", busy, resp_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    int a, r, nw, nr; bit ok; logic [2:0] id; logic [BITS-1:0] d; logic e;
    drive_req(0, 32'h0003_0005, 1'b0, 1'b0);
    wait_accept(0, a, ok);
    checks++; if (!ok) begin errors++; $display("FAIL add_accept: got none expected req_ready[0]"); end
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++; if (!ok || r - a != 6) begin errors++; $display("FAIL add_latency: got %0d expected 6", r - a); end
    checks++; if (id !== 3'd0) begin errors++; $display("FAIL add_id: got %0d expected 0", id); end
    checks++; if (d !== 32'h0000_0008) begin errors++; $display("FAIL add_data: got %h expected 00000008", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL add_err: got %b expected 0", e); end
    ref_prev = 32'h0000_0008;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || resp_data !== 32'h8 || busy !== 1'b0)
      begin errors++; $display("FAIL add_hold: got valid=%b data=%h busy=%b expected 0/8/0", resp_valid, resp_data, busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int a, prev_a, r, nw, nr, g; bit ok; logic [2:0] id; logic [BITS-1:0] d, exp_d; logic e;
    do_reset();
    prev_a = 0;
    for (int i = 0; i < NREQ; i++)
      drive_req(i, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int k = 0; k < 6; k++) begin
      ok = 1'b0; g = 0; a = 0;
      for (int t = 0; t < 40 && !ok; t++) begin
        @(negedge clk);
        if (|req_ready) begin ok = 1'b1; g = req_ready[1] ? 1 : 0; a = cyc; end
      end
      checks++;
      if (!ok || g != k % 2) begin errors++; $display("FAIL rr_order[%0d]: got %0d expected %0d", k, g, k % 2); end
      if (!ok) break;
      if (k > 0) begin
        checks++;
        if (a - prev_a != 7) begin errors++; $display("FAIL rr_spacing[%0d]: got %0d expected 7", k, a - prev_a); end
      end
      prev_a = a;
      exp_d = ref_acc(ref_prev, req_data[g*BITS +: BITS], req_nadd_sub[g], req_use_prev[g]);
      @(posedge clk); #1;
      if (k == 5) req_valid = '0;
      else drive_req(g, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_resp(r, ok, id, d, e, nw, nr);
      checks++;
      if (!ok || id !== 3'(g) || d !== exp_d || e !== 1'b0)
        begin errors++; $display("FAIL rr_resp[%0d]: got id=%0d data=%h err=%b expected id=%0d data=%h err=0",
                                 k, id, d, e, g, exp_d); end
      ref_prev = exp_d;
    end
  endtask

  task automatic test_sub_prev();
    int a0, a1, r, nw, nr; bit ok, stable; logic [2:0] id; logic [BITS-1:0] d; logic e;
    drive_req(0, 32'h0032_0032, 1'b0, 1'b0);
    wait_accept(0, a0, ok);
    drive_req(1, 32'd30, 1'b1, 1'b1);
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++; if (!ok || d !== 32'd100) begin errors++; $display("FAIL prev_setup: got %0d expected 100", d); end
    ref_prev = 32'd100;
    wait_accept(1, a1, ok);
    checks++; if (!ok || a1 - a0 != 7) begin errors++; $display("FAIL held_while_busy: got %0d expected 7", a1 - a0); end
    stable = 1'b1; ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1'b1; id = resp_id; d = resp_data; e = resp_err; end
      else if (dp_nadd_sub !== 1'b1 || dp_use_prev !== 1'b1 || dp_wdata !== 32'd30) stable = 1'b0;
    end
    @(posedge clk); #1;
    checks++; if (!stable) begin errors++; $display("FAIL sub_dp_stable: got changing op/prev/wdata expected 1/1/30"); end
    checks++;
    if (!ok || id !== 3'd1 || d !== 32'd70 || e !== 1'b0)
      begin errors++; $display("FAIL sub_resp: got id=%0d data=%0d err=%b expected id=1 data=70 err=0", id, d, e); end
    ref_prev = 32'd70;
  endtask

  task automatic test_timeout();
    int a, r, nw, nr; bit ok; logic [2:0] id; logic [BITS-1:0] d, exp_d; logic e;
    wr_dly = 1000;
    drive_req(0, $urandom, 1'b0, 1'b1);
    wait_accept(0, a, ok);
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++; if (!ok || nw != TIMEOUT) begin errors++; $display("FAIL wr_timeout_len: got %0d expected %0d", nw, TIMEOUT); end
    checks++;
    if (e !== 1'b1 || d !== '0 || id !== 3'd0)
      begin errors++; $display("FAIL wr_timeout_resp: got err=%b data=%h id=%0d expected 1/0/0", e, d, id); end
    wr_dly = 0; rd_dly = 1000;
    drive_req(1, $urandom, 1'b1, 1'b0);
    wait_accept(1, a, ok);
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++;
    if (!ok || nr != TIMEOUT || nw != 2 || e !== 1'b1 || d !== '0 || id !== 3'd1 || r - a != 19)
      begin errors++; $display("FAIL rd_timeout: got nrd=%0d nwr=%0d err=%b data=%h id=%0d lat=%0d expected %0d/2/1/0/1/19",
                               nr, nw, e, d, id, r - a, TIMEOUT); end
    rd_dly = 0;
    drive_req(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    exp_d = ref_acc(ref_prev, req_data[BITS-1:0], req_nadd_sub[0], req_use_prev[0]);
    wait_accept(0, a, ok);
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++;
    if (!ok || d !== exp_d || e !== 1'b0 || r - a != 6)
      begin errors++; $display("FAIL after_timeout: got data=%h err=%b lat=%0d expected %h/0/6", d, e, r - a, exp_d); end
    ref_prev = exp_d;
  endtask

  task automatic test_reset_mid_rd();
    int a, r, nw, nr; bit ok, quiet; logic [2:0] id; logic [BITS-1:0] d, exp_d; logic e;
    rd_dly = 1000;
    drive_req(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    wait_accept(0, a, ok);
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin @(negedge clk); if (dp_valid && !dp_we) ok = 1'b1; end
    checks++; if (!ok) begin errors++; $display("FAIL reach_rd: got no read phase expected one"); end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || dp_valid !== 1'b0 || resp_valid !== 1'b0)
      begin errors++; $display("FAIL mid_rd_reset: got busy=%b dp_valid=%b resp_valid=%b expected 0", busy, dp_valid, resp_valid); end
    quiet = 1'b1;
    for (int t = 0; t < 10; t++) begin @(negedge clk); if (resp_valid !== 1'b0) quiet = 1'b0; end
    checks++; if (!quiet) begin errors++; $display("FAIL aborted_no_resp: got resp_valid expected none"); end
    rd_dly = 0;
    @(posedge clk); #1;
    drive_req(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive_req(1, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    exp_d = ref_acc(ref_prev, req_data[BITS-1:0], req_nadd_sub[0], req_use_prev[0]);
    @(negedge clk);
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL ptr_reset_tie: got %b expected 01", req_ready); end
    @(posedge clk); #1; req_valid[0] = 1'b0;
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++;
    if (!ok || id !== 3'd0 || d !== exp_d || e !== 1'b0)
      begin errors++; $display("FAIL tie_resp0: got id=%0d data=%h expected 0/%h", id, d, exp_d); end
    ref_prev = exp_d;
    exp_d = ref_acc(ref_prev, req_data[BITS +: BITS], req_nadd_sub[1], req_use_prev[1]);
    wait_accept(1, a, ok);
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++;
    if (!ok || id !== 3'd1 || d !== exp_d || e !== 1'b0)
      begin errors++; $display("FAIL tie_resp1: got id=%0d data=%h expected 1/%h", id, d, exp_d); end
    ref_prev = exp_d;
  endtask

  task automatic test_ready_at_expiry();
    int a, r, nw, nr; bit ok; logic [2:0] id; logic [BITS-1:0] d, exp_d; logic e;
    rd_dly = TIMEOUT - 2;
    drive_req(0, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    exp_d = ref_acc(ref_prev, req_data[BITS-1:0], req_nadd_sub[0], req_use_prev[0]);
    wait_accept(0, a, ok);
    wait_resp(r, ok, id, d, e, nw, nr);
    checks++;
    if (!ok || e !== 1'b0 || d !== exp_d || nr != TIMEOUT || r - a != 19)
      begin errors++; $display("FAIL ready_at_expiry: got err=%b data=%h nrd=%0d lat=%0d expected 0/%h/%0d/19",
                               e, d, nr, r - a, exp_d, TIMEOUT); end
    ref_prev = exp_d;
    rd_dly = 0;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; req_nadd_sub = '0; req_use_prev = '0;
    test_reset();
    test_single_add();
    test_contention();
    test_sub_prev();
    test_timeout();
    test_reset_mid_rd();
    test_ready_at_expiry();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule

// File: doc/add_sub_sched.md
Name: add_sub_sched

Overview:
Round-robin scheduler that shares one add_sub_accum-style datapath between NREQ requesters.
- Accepts one operation per grant: operand, add/sub select and use-prev select.
- Sequences the datapath's two-phase valid/ready protocol: operand write, then result read.
- Returns the result to the winning requester tagged with its index.
- A watchdog aborts a phase whose datapath ready never arrives.

Parameters:
BITS, 32, operand/result width
NREQ, 2, number of requesters (2..8)
TIMEOUT, 15, max cycles per datapath phase without dp_ready before abort (>=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_valid  input  NREQ  per-requester request; held until accepted
req_ready  output  NREQ  one-hot accept strobe
req_nadd_sub  input  NREQ  per-requester op: 0 add, 1 subtract
req_use_prev  input  NREQ  per-requester: 1 combine with datapath prev_result, 0 use packed halves
req_data  input  NREQ*BITS  per-requester operand, requester i at [i*BITS +: BITS]
resp_valid  output  1  one-cycle result strobe
resp_id  output  3  index of requester being answered
resp_data  output  BITS  result
resp_err  output  1  timeout flag, valid with resp_valid
busy  output  1  high in every state except IDLE
dp_valid  output  1  datapath valid
dp_we  output  1  datapath write enable: 1 operand write, 0 result read
dp_nadd_sub  output  1  datapath op select
dp_use_prev  output  1  datapath prev select
dp_wdata  output  BITS  datapath operand
dp_ready  input  1  datapath acknowledge, one-cycle pulse
dp_rdata  input  BITS  datapath result

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; RR pointer 0; watchdog counter 0; operand/op/id registers 0.
  - Reset mid-operation aborts with no resp_valid; dp_valid drops in the next cycle.
- States: IDLE, WR, GAP, RD, RESP.
- IDLE:
  - Grant = first i with req_valid[i], searching from pointer upward, wrapping mod NREQ.
  - If any request: req_ready[grant]=1 (combinational, this cycle only).
  - Latch req_data, req_nadd_sub, req_use_prev and grant index; pointer <= (grant+1) mod NREQ; -> WR.
  - req_ready is all-zero in every other state.
- WR:
  - dp_valid=1, dp_we=1, dp_wdata=latched operand.
  - dp_ready=1 -> GAP.
- GAP: dp_valid=0 for exactly one cycle, so the datapath's ready toggle re-arms; -> RD.
- RD:
  - dp_valid=1, dp_we=0.
  - dp_ready=1 -> capture dp_rdata into resp_data, resp_err=0; -> RESP.
- dp_nadd_sub, dp_use_prev, dp_wdata are driven from the latched registers and stay stable from WR through RD.
- Watchdog:
  - Counter clears on entry to WR and to RD; increments each cycle in WR/RD without dp_ready.
  - Reaching TIMEOUT -> RESP with resp_err=1, resp_data=0.
  - dp_ready in the same cycle as expiry wins (normal completion).
- RESP:
  - resp_valid=1, resp_id=latched index, for exactly one cycle; -> IDLE.
  - resp_data/resp_id/resp_err hold their values until the next RESP.
- Latency: with a datapath that asserts ready the cycle after valid, resp_valid is asserted 6 cycles after the accept cycle (accept=A; WR A+1..A+2; GAP A+3; RD A+4..A+5; RESP A+6). Minimum spacing between accepts is 7 cycles.
- Fairness: the pointer advances only on grant. A continuously requesting requester cannot win twice in a row while another requester is waiting.
- Requests raised while busy are not dropped: they wait, and req_valid must stay high.
- resp_id is zero-extended; NREQ>8 is unsupported.

Test Plan:
1. Single add: req0 data=0x0003_0005, nadd_sub=0, use_prev=0, accumulator model attached -> req_ready[0] at A, resp_valid at A+6, resp_id=0, resp_data=0x0000_0008, resp_err=0.
2. Contention after reset: req0 and req1 both asserted in the same cycle -> req0 answered first, then req1. Repeat with both held -> grant order 0,1,0,1; no requester served twice consecutively.
3. Subtract with prev: model prev_result=100, req1 data=30, nadd_sub=1, use_prev=1 -> resp_id=1, resp_data=70. dp_nadd_sub and dp_use_prev stay constant from WR through RD.
4. Timeout: dp_ready tied 0 -> dp_valid high exactly TIMEOUT(15) cycles in WR, then resp_valid with resp_err=1, resp_data=0; then IDLE and the next request is served normally.
5. Reset mid-RD: assert reset for 1 cycle while in RD -> no resp_valid, busy=0 and dp_valid=0 the next cycle, pointer=0 (req0 wins a subsequent tie).
6. Ready at expiry: dp_ready arrives in the same cycle the watchdog expires in RD -> normal response, resp_err=0, resp_data=dp_rdata.
